// File: rtl/xor_accum_multi.sv
// Multi-channel XOR accumulator: CH channel states fold both parties' inputs each accepted beat.
// Optional macro XOR_ACCUM_ROT_EN rotates each channel state left by one before folding.
module xor_accum_multi #(
  parameter int W  = 8,
  parameter int CH = 3,
  parameter int CC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH*W-1:0]           p_init,
  input  logic [CH*W-1:0]           g_init,
  input  logic [CH*W-1:0]           p_input,
  input  logic [CH*W-1:0]           g_input,
  input  logic                      in_valid,
  output logic [CH*W-1:0]           acc,
  output logic [W-1:0]              o,
  output logic                      o_valid,
  output logic [$clog2(CC+1)-1:0]   count,
  output logic                      done
);

  localparam int CW = $clog2(CC + 1);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [CH*W-1:0]   r_acc;
  logic [W-1:0]      r_o;
  logic              r_oValid;
  logic [CW-1:0]     r_count;
  logic              w_accept;
  logic              w_lastBeat;
  logic [CH*W-1:0]   w_accNext;
  logic [W-1:0]      w_oNext;

  // The shift form degenerates to identity for W=1 without an out-of-range slice.
  function automatic logic [W-1:0] fStep(input logic [W-1:0] x);
`ifdef XOR_ACCUM_ROT_EN
    return (x << 1) | (x >> (W - 1));
`else
    return x;
`endif
  endfunction

  assign w_accept   = in_valid & (r_state == S_RUN) & ~rst;
  assign w_lastBeat = (r_count == CW'(CC - 1));

  always_comb begin
    w_accNext = '0;
    w_oNext   = '0;
    for (int c = 0; c < CH; c++) begin
      w_accNext[c*W +: W] = fStep(r_acc[c*W +: W]) ^ p_input[c*W +: W] ^ g_input[c*W +: W];
      w_oNext             = w_oNext ^ w_accNext[c*W +: W];
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_accept && w_lastBeat) begin
      w_stateNext = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Reset loads both parties' init words; o_valid mirrors acceptance one edge late.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= p_init ^ g_init;
      r_o      <= '0;
      r_oValid <= 1'b0;
      r_count  <= '0;
    end else begin
      r_oValid <= w_accept;
      if (w_accept) begin
        r_acc   <= w_accNext;
        r_o     <= w_oNext;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign acc     = r_acc;
  assign o       = r_o;
  assign o_valid = r_oValid;
  assign count   = r_count;
  assign done    = (r_state == S_DONE);

endmodule
